crcu_rst_ctl_multi: RTL and testbench
=====================================

Name: crcu_rst_ctl_multi

Overview:
- Parametrised multi-channel reset generator for the CRCU. It replaces the single-channel, elaboration-time reset selection with run-time, per-channel control.
- Each channel reads its own APB-written 32-bit control word:
  - enable
  - sync/async assertion mode
  - output polarity
  - programmable hold width
  - chain-to-previous-channel
- On a trigger, each channel produces a timed reset pulse with a synchronised release.
- Sits between the APB register bank and the peripheral reset fan-out.

Parameters:
- NUM_CH, 4: number of independent reset channels (1..16).
- HOLD_W, 8: width of the hold-count field and counter.
- SYNC_STAGES, 2: release-synchroniser depth in async mode (≥1).

Ports:
- CRCU_CLK  input  1  CRCU clock; all flops on rising edge.
- CRCU_RST  input  1  asynchronous, active-low reset.
- rst_ctl_reg  input  NUM_CH*32  channel i occupies bits [32i+31:32i].
- rst_req  input  NUM_CH  per-channel software trigger, level-sampled each cycle.
- rst_out  output  NUM_CH  generated resets, per-channel polarity.
- rst_busy  output  NUM_CH  channel not IDLE.
- rst_done  output  NUM_CH  one-cycle pulse on normal completion.

Behaviour:
- Control word fields:
  - bit0 EN
  - bit1 ASYNC (1 = async assertion)
  - bit2 POL (1 = active-high, 0 = active-low)
  - bit3 CHAIN
  - bits [8+HOLD_W-1:8] HOLD
  - all other bits ignored.
- Reset: CRCU_RST low forces every channel to IDLE, counters 0, rst_busy=0, rst_done=0.
  - rst_out = ~POL of the live register (deasserted level).
- Per-channel FSM:
  - IDLE -> ASSERT on trigger.
  - ASSERT -> RELEASE when the hold counter expires (ASYNC=1).
  - ASSERT -> IDLE when the hold counter expires (ASYNC=0).
  - RELEASE -> IDLE after SYNC_STAGES cycles.
- Trigger is (rst_req[i] | (CHAIN & rst_done[i-1])) & EN & state==IDLE. CHAIN is ignored on channel 0.
- On trigger, ASYNC, POL and HOLD are latched. Latched values govern the output until return to IDLE; in IDLE the output follows the live POL.
- Effective hold = HOLD, except HOLD=0 counts as 1.
- Sync mode:
  - rst_out is asserted from the edge that samples the trigger.
  - It stays asserted for exactly hold cycles, then deasserts on the same edge that enters IDLE.
  - rst_done pulses in the first IDLE cycle.
- Async mode:
  - rst_out asserts combinationally in the trigger cycle.
  - It stays asserted through hold ASSERT cycles plus SYNC_STAGES RELEASE cycles, then deasserts.
  - rst_done pulses in the first IDLE cycle.
- rst_busy is registered: high from the edge after the trigger until IDLE is re-entered.
- rst_req while busy: ignored; no queuing.
- EN cleared mid-operation: the channel aborts to IDLE on the next edge. rst_out is deasserted from that edge, with no rst_done. The output is forced deasserted combinationally while EN=0.
- CRCU_RST asserted mid-operation: immediate abort with reset values and no done.
- Chaining:
  - Channel i triggers in the cycle channel i-1's rst_done is high, giving one cycle between chained pulses.
  - A chain of k channels fires sequentially.
  - A disabled channel breaks the chain.
- Simultaneous rst_req and chain trigger on one channel: a single trigger.
- Counter arithmetic: HOLD_W-bit down-counter loaded with hold-1, expiring at 0. No wrap.

Decomposition:
- Package crcu_rst_pkg:
  - field index localparams (EN_B, ASYNC_B, POL_B, CHAIN_B, HOLD_LSB)
  - state enum {IDLE, ASSERT, RELEASE}
- Sub-module crcu_rst_chan: one channel's FSM, counter, synchroniser and output mux. The top instantiates it NUM_CH times in a generate loop and wires the chain signals.

Test Plan:
- Ch0 sync pulse: EN=1, ASYNC=0, POL=0, HOLD=5, rst_req pulse at cycle 10 -> rst_out[0]=0 for cycles 11-15, rst_done[0] at cycle 16, rst_busy[0] for cycles 11-15.
- Ch1 async pulse: ASYNC=1, POL=1, HOLD=3, SYNC_STAGES=2, request at cycle 20 -> rst_out[1]=1 combinationally in cycle 20 through cycle 25, done at cycle 26.
- HOLD=0 -> identical to HOLD=1: one-cycle sync assertion. A rst_req held high during busy produces no second pulse until IDLE.
- Chain: ch0-3 EN=1, CHAIN=1 on ch1-3, HOLD=2, sync, ch0 request only -> four sequential pulses, each starting in the cycle of the previous done. Clearing EN on ch2 stops the chain at ch1.
- Abort: clear EN mid-ASSERT -> rst_out deasserted immediately, no done. Assert CRCU_RST mid-RELEASE -> all outputs at ~POL, busy=0.
- Polarity change during busy: write POL mid-pulse -> output unchanged until IDLE, then follows the new POL.

Source files
------------

// File: rtl/crcu_rst_pkg.sv
// CRCU reset controller shared definitions.
// Control-word field positions and channel FSM states.
package crcu_rst_pkg;

  localparam int EN_B     = 0;
  localparam int ASYNC_B  = 1;
  localparam int POL_B    = 2;
  localparam int CHAIN_B  = 3;
  localparam int HOLD_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/crcu_rst_chan.sv
// One CRCU reset channel: FSM, hold counter,
// release synchroniser and polarity output mux.
module crcu_rst_chan
  import crcu_rst_pkg::*;
#(
  parameter int HOLD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ctl,
  input  logic        req,
  input  logic        chain_in,
  output logic        rst_out,
  output logic        busy,
  output logic        done
);

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      cnt_q, cnt_d;
  logic [HOLD_W-1:0]      hold;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   sync_sh;
  logic                   async_q, async_d;
  logic                   pol_q, pol_d;
  logic                   done_q, done_d;
  logic                   en, idle, trig;
  logic                   act, pol_sel;
  logic                   unused_ctl;

  assign en         = ctl[EN_B];
  assign hold       = ctl[HOLD_LSB +: HOLD_W];
  assign idle       = (state_q == IDLE);
  assign unused_ctl = ^ctl;
  assign sync_sh    = {sync_q, 1'b1};

  assign trig = (req | (ctl[CHAIN_B] & chain_in))
              & en & idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    async_d = async_q;
    pol_d   = pol_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ASSERT;
          async_d = ctl[ASYNC_B];
          pol_d   = ctl[POL_B];
          // HOLD=0 behaves as a one-cycle hold
          cnt_d   = (hold == '0) ? '0
                  : hold - HOLD_W'(1);
        end
      end
      ASSERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (async_q) begin
          state_d = RELEASE;
          sync_d  = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      RELEASE: begin
        sync_d = sync_sh[SYNC_STAGES-1:0];
        if (sync_d[SYNC_STAGES-1]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync_q  <= '0;
      async_q <= 1'b0;
      pol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      async_q <= async_d;
      pol_q   <= pol_d;
      done_q  <= done_d;
    end
  end

  // async mode asserts in the trigger cycle itself
  assign act = rst_n & en
             & (!idle | (trig & ctl[ASYNC_B]));
  assign pol_sel = idle ? ctl[POL_B] : pol_q;
  assign rst_out = act ? pol_sel : ~pol_sel;
  assign busy    = !idle;
  assign done    = done_q;

endmodule

// File: rtl/crcu_rst_ctl_multi.sv
// Multi-channel CRCU reset generator: NUM_CH
// independently controlled, optionally chained channels.
module crcu_rst_ctl_multi
  import crcu_rst_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CRCU_CLK,
  input  logic                CRCU_RST,
  input  logic [NUM_CH*32-1:0] rst_ctl_reg,
  input  logic [NUM_CH-1:0]   rst_req,
  output logic [NUM_CH-1:0]   rst_out,
  output logic [NUM_CH-1:0]   rst_busy,
  output logic [NUM_CH-1:0]   rst_done
);

  logic [NUM_CH-1:0] chain_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (i == 0) begin : g_head
      assign chain_in[i] = 1'b0;
    end else begin : g_link
      assign chain_in[i] = rst_done[i-1];
    end

    crcu_rst_chan #(
      .HOLD_W      (HOLD_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (CRCU_CLK),
      .rst_n    (CRCU_RST),
      .ctl      (rst_ctl_reg[32*i +: 32]),
      .req      (rst_req[i]),
      .chain_in (chain_in[i]),
      .rst_out  (rst_out[i]),
      .busy     (rst_busy[i]),
      .done     (rst_done[i])
    );
  end

endmodule

// File: tb/tb_crcu_rst_ctl_multi.sv
// Scoreboard bench for crcu_rst_ctl_multi.
// Expected per-cycle channel values are queued then compared.
module tb_crcu_rst_ctl_multi;

  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH*32-1:0] ctl_reg = '0;
  logic [NUM_CH-1:0] req = '0;
  logic [NUM_CH-1:0] rst_out, busy, done;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int   cyc;
    int   ch;
    logic out;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];

  crcu_rst_ctl_multi #(
    .NUM_CH      (NUM_CH),
    .HOLD_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .CRCU_CLK    (clk),
    .CRCU_RST    (rst_n),
    .rst_ctl_reg (ctl_reg),
    .rst_req     (req),
    .rst_out     (rst_out),
    .rst_busy    (busy),
    .rst_done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cw(
    bit en, bit as, bit pol, bit ch, int hold);
    logic [31:0] w;
    w = 32'hA5A5_0070;
    w[0] = en;
    w[1] = as;
    w[2] = pol;
    w[3] = ch;
    w[15:8] = hold[7:0];
    return w;
  endfunction

  task automatic push(int c, int ch, bit asrt,
                      bit pol, bit b, bit d);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.out  = asrt ? pol : ~pol;
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    ctl_reg[31:0]   = cw(1, 0, 0, 0, 3);
    ctl_reg[63:32]  = cw(1, 1, 1, 0, 3);
    ctl_reg[95:64]  = cw(0, 0, 1, 0, 3);
    ctl_reg[127:96] = cw(0, 1, 0, 0, 3);
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    checks += 3;
    if (rst_out !== 4'b1001) begin
      errors++;
      $display("FAIL reset out: got %b want 1001", rst_out);
    end
    if (busy !== 4'b0000) begin
      errors++;
      $display("FAIL reset busy: got %b want 0000", busy);
    end
    if (done !== 4'b0000) begin
      errors++;
      $display("FAIL reset done: got %b want 0000", done);
    end
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sync();
    int t0;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    ctl_reg = '0;
    ctl_reg[31:0] = cw(1, 0, 0, 0, 5);
    req = 4'b0001;
    for (int k = 0; k < 9; k++)
      push(t0 + k, 0, k >= 1 && k <= 5, 1'b0,
           k >= 1 && k <= 5, k == 6);
    for (int k = 0; k < 9; k++) begin
      if (k == 1) req = '0;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out[e.ch] !== e.out) begin
          errors++;
          $display("FAIL sync out k%0d: got %b want %b",
                   cyc - t0, rst_out[e.ch], e.out);
        end
        if (busy[e.ch] !== e.busy) begin
          errors++;
          $display("FAIL sync busy k%0d: got %b want %b",
                   cyc - t0, busy[e.ch], e.busy);
        end
        if (done[e.ch] !== e.done) begin
          errors++;
          $display("FAIL sync done k%0d: got %b want %b",
                   cyc - t0, done[e.ch], e.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async();
    int t0;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    ctl_reg = '0;
    ctl_reg[63:32] = cw(1, 1, 1, 0, 3);
    req = 4'b0010;
    for (int k = 0; k < 9; k++)
      push(t0 + k, 1, k <= 5, 1'b1,
           k >= 1 && k <= 5, k == 6);
    for (int k = 0; k < 9; k++) begin
      if (k == 1) req = '0;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out[e.ch] !== e.out) begin
          errors++;
          $display("FAIL async out k%0d: got %b want %b",
                   cyc - t0, rst_out[e.ch], e.out);
        end
        if (busy[e.ch] !== e.busy) begin
          errors++;
          $display("FAIL async busy k%0d: got %b want %b",
                   cyc - t0, busy[e.ch], e.busy);
        end
        if (done[e.ch] !== e.done) begin
          errors++;
          $display("FAIL async done k%0d: got %b want %b",
                   cyc - t0, done[e.ch], e.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold0();
    int t0;
    exp_t e;
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      t0 = cyc;
      ctl_reg = '0;
      ctl_reg[31:0] = cw(1, 0, 0, 0, h);
      req = 4'b0001;
      for (int k = 0; k < 9; k++)
        push(t0 + k, 0, k == 1 || k == 3 || k == 5,
             1'b0, k == 1 || k == 3 || k == 5,
             k == 2 || k == 4 || k == 6);
      for (int k = 0; k < 9; k++) begin
        if (k == 5) req = '0;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          checks += 3;
          if (rst_out[e.ch] !== e.out) begin
            errors++;
            $display("FAIL hold%0d out k%0d: got %b want %b",
                     h, cyc - t0, rst_out[e.ch], e.out);
          end
          if (busy[e.ch] !== e.busy) begin
            errors++;
            $display("FAIL hold%0d busy k%0d: got %b want %b",
                     h, cyc - t0, busy[e.ch], e.busy);
          end
          if (done[e.ch] !== e.done) begin
            errors++;
            $display("FAIL hold%0d done k%0d: got %b want %b",
                     h, cyc - t0, done[e.ch], e.done);
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_chain(bit brk);
    int t0;
    bit live;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    ctl_reg[31:0] = cw(1, 0, 0, 1, 2);
    for (int j = 1; j < NUM_CH; j++)
      ctl_reg[32*j +: 32] = cw(!(brk && j == 2), 0, 0, 1, 2);
    req = 4'b0001;
    for (int k = 0; k < 15; k++)
      for (int j = 0; j < NUM_CH; j++) begin
        live = !(brk && j >= 2);
        push(t0 + k, j,
             live && k >= 1 + 3*j && k <= 2 + 3*j, 1'b0,
             live && k >= 1 + 3*j && k <= 2 + 3*j,
             live && k == 3 + 3*j);
      end
    for (int k = 0; k < 15; k++) begin
      if (k == 1) req = '0;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out[e.ch] !== e.out) begin
          errors++;
          $display("FAIL chain%0d out ch%0d k%0d: got %b want %b",
                   brk, e.ch, cyc - t0, rst_out[e.ch], e.out);
        end
        if (busy[e.ch] !== e.busy) begin
          errors++;
          $display("FAIL chain%0d busy ch%0d k%0d: got %b want %b",
                   brk, e.ch, cyc - t0, busy[e.ch], e.busy);
        end
        if (done[e.ch] !== e.done) begin
          errors++;
          $display("FAIL chain%0d done ch%0d k%0d: got %b want %b",
                   brk, e.ch, cyc - t0, done[e.ch], e.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int t0;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    ctl_reg = '0;
    ctl_reg[31:0] = cw(1, 0, 0, 0, 6);
    req = 4'b0001;
    for (int k = 0; k < 10; k++)
      push(t0 + k, 0, k == 1 || k == 2, 1'b0,
           k >= 1 && k <= 3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k == 1) req = '0;
      if (k == 3) ctl_reg[0] = 1'b0;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out[e.ch] !== e.out) begin
          errors++;
          $display("FAIL en_abort out k%0d: got %b want %b",
                   cyc - t0, rst_out[e.ch], e.out);
        end
        if (busy[e.ch] !== e.busy) begin
          errors++;
          $display("FAIL en_abort busy k%0d: got %b want %b",
                   cyc - t0, busy[e.ch], e.busy);
        end
        if (done[e.ch] !== e.done) begin
          errors++;
          $display("FAIL en_abort done k%0d: got %b want %b",
                   cyc - t0, done[e.ch], e.done);
        end
      end
      @(negedge clk);
    end
    t0 = cyc;
    ctl_reg[63:32] = cw(1, 1, 1, 0, 2);
    req = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      push(t0 + k, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(t0 + k, 1, k <= 2, 1'b1,
           k == 1 || k == 2, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 1) req = '0;
      if (k == 3) rst_n = 1'b0;
      if (k == 5) rst_n = 1'b1;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out[e.ch] !== e.out) begin
          errors++;
          $display("FAIL rst_abort out ch%0d k%0d: got %b want %b",
                   e.ch, cyc - t0, rst_out[e.ch], e.out);
        end
        if (busy[e.ch] !== e.busy) begin
          errors++;
          $display("FAIL rst_abort busy ch%0d k%0d: got %b want %b",
                   e.ch, cyc - t0, busy[e.ch], e.busy);
        end
        if (done[e.ch] !== e.done) begin
          errors++;
          $display("FAIL rst_abort done ch%0d k%0d: got %b want %b",
                   e.ch, cyc - t0, done[e.ch], e.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pol();
    int t0;
    exp_t e;
    @(negedge clk);
    t0 = cyc;
    ctl_reg = '0;
    ctl_reg[31:0] = cw(1, 0, 0, 0, 4);
    req = 4'b0001;
    for (int k = 0; k < 8; k++)
      push(t0 + k, 0, k >= 1 && k <= 4, k >= 5,
           k >= 1 && k <= 4, k == 5);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) req = '0;
      if (k == 2) ctl_reg[31:0] = cw(1, 0, 1, 0, 4);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks += 3;
        if (rst_out[e.ch] !== e.out) begin
          errors++;
          $display("FAIL pol out k%0d: got %b want %b",
                   cyc - t0, rst_out[e.ch], e.out);
        end
        if (busy[e.ch] !== e.busy) begin
          errors++;
          $display("FAIL pol busy k%0d: got %b want %b",
                   cyc - t0, busy[e.ch], e.busy);
        end
        if (done[e.ch] !== e.done) begin
          errors++;
          $display("FAIL pol done k%0d: got %b want %b",
                   cyc - t0, done[e.ch], e.done);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_async();
    test_hold0();
    test_chain(1'b0);
    test_chain(1'b1);
    test_abort();
    test_pol();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left want 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
